// File: rtl/reg_write_ctrl.sv
// Write-port controller for the 32x32 register file: round-robin WB0/WB1 arbitration
// plus interrupt context save (PC, then RAND). Optional macro: REG_WRITE_X0_DROP_EN.
module reg_write_ctrl #(
    parameter int unsigned INT_PC_REG   = 30,
    parameter int unsigned INT_RAND_REG = 31
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        WB0_REQ,
    input  logic [4:0]  WB0_ADDR,
    input  logic [31:0] WB0_DATA,
    output logic        WB0_GNT,
    input  logic        WB1_REQ,
    input  logic [4:0]  WB1_ADDR,
    input  logic [31:0] WB1_DATA,
    output logic        WB1_GNT,
    input  logic        INT_REQ,
    input  logic [31:0] INT_PC,
    input  logic [31:0] RAND_IN,
    output logic        INT_ACK,
    output logic        BUSY,
    output logic [31:0] RF_IN,
    output logic [4:0]  RF_INADDRESS,
    output logic        RF_WRITE_EN
);

    typedef enum logic [1:0] {
        IDLE,
        SAVE_RAND,
        WAIT_REL
    } state_e;

    state_e      state_q;
    logic        ptr_q;
    logic [31:0] hold_q;
    logic        ack_q;
    logic [31:0] rf_data_q;
    logic [4:0]  rf_addr_q;
    logic        rf_we_q;

    logic        arb_en;
    logic        gnt0;
    logic        gnt1;
    logic [4:0]  wb_addr_d;
    logic [31:0] wb_data_d;
    logic        wb_we_d;

    always_comb begin
        arb_en    = !RESET && (((state_q == IDLE) && !INT_REQ) || (state_q == WAIT_REL));
        // ptr_q=0 favours WB0 on contention, ptr_q=1 favours WB1
        gnt0      = arb_en && WB0_REQ && (!WB1_REQ || !ptr_q);
        gnt1      = arb_en && WB1_REQ && (!WB0_REQ || ptr_q);
        wb_addr_d = gnt1 ? WB1_ADDR : WB0_ADDR;
        wb_data_d = gnt1 ? WB1_DATA : WB0_DATA;
`ifdef REG_WRITE_X0_DROP_EN
        wb_we_d   = (gnt0 || gnt1) && (wb_addr_d != 5'd0);
`else
        wb_we_d   = gnt0 || gnt1;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            hold_q    <= '0;
            ack_q     <= 1'b0;
            rf_data_q <= '0;
            rf_addr_q <= '0;
            rf_we_q   <= 1'b0;
        end else begin
            rf_we_q <= 1'b0;
            // Grants only occur in arbitrating states, so this never collides with the save writes below
            if (gnt0 || gnt1) begin
                rf_addr_q <= wb_addr_d;
                rf_data_q <= wb_data_d;
                rf_we_q   <= wb_we_d;
                ptr_q     <= gnt0;
            end
            case (state_q)
                IDLE: begin
                    if (INT_REQ) begin
                        rf_addr_q <= 5'(INT_PC_REG);
                        rf_data_q <= INT_PC;
                        rf_we_q   <= 1'b1;
                        hold_q    <= RAND_IN;
                        state_q   <= SAVE_RAND;
                    end
                end
                SAVE_RAND: begin
                    rf_addr_q <= 5'(INT_RAND_REG);
                    rf_data_q <= hold_q;
                    rf_we_q   <= 1'b1;
                    ack_q     <= 1'b1;
                    state_q   <= WAIT_REL;
                end
                WAIT_REL: begin
                    if (!INT_REQ) begin
                        ack_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign WB0_GNT      = gnt0;
    assign WB1_GNT      = gnt1;
    assign INT_ACK      = ack_q;
    assign BUSY         = (state_q != IDLE);
    assign RF_IN        = rf_data_q;
    assign RF_INADDRESS = rf_addr_q;
    assign RF_WRITE_EN  = rf_we_q;

endmodule

// File: tb/tb_reg_write_ctrl.sv
// Directed bench for reg_write_ctrl; expected register-file writes are queued when a
// cycle's stimulus is applied and compared when they appear on RF_* one cycle later.
module tb_reg_write_ctrl;

    logic        CLK;
    logic        RESET;
    logic        WB0_REQ;
    logic [4:0]  WB0_ADDR;
    logic [31:0] WB0_DATA;
    logic        WB0_GNT;
    logic        WB1_REQ;
    logic [4:0]  WB1_ADDR;
    logic [31:0] WB1_DATA;
    logic        WB1_GNT;
    logic        INT_REQ;
    logic [31:0] INT_PC;
    logic [31:0] RAND_IN;
    logic        INT_ACK;
    logic        BUSY;
    logic [31:0] RF_IN;
    logic [4:0]  RF_INADDRESS;
    logic        RF_WRITE_EN;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    int  n_vec = 0;
    int  n_err = 0;

    reg_write_ctrl #(.INT_PC_REG(30), .INT_RAND_REG(31)) dut (
        .CLK(CLK), .RESET(RESET),
        .WB0_REQ(WB0_REQ), .WB0_ADDR(WB0_ADDR), .WB0_DATA(WB0_DATA), .WB0_GNT(WB0_GNT),
        .WB1_REQ(WB1_REQ), .WB1_ADDR(WB1_ADDR), .WB1_DATA(WB1_DATA), .WB1_GNT(WB1_GNT),
        .INT_REQ(INT_REQ), .INT_PC(INT_PC), .RAND_IN(RAND_IN),
        .INT_ACK(INT_ACK), .BUSY(BUSY),
        .RF_IN(RF_IN), .RF_INADDRESS(RF_INADDRESS), .RF_WRITE_EN(RF_WRITE_EN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        wr_t e;
        @(posedge CLK);
        #1;
        n_vec++;
        assert (sb.size() > 0) else begin
            n_err++;
            $error("FAIL sb_underflow: observed 0 entries expected 1");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rf_we", RF_WRITE_EN, e.we);
            if (e.we) begin
                check("rf_addr", RF_INADDRESS, e.addr);
                check("rf_data", RF_IN, e.data);
            end
        end
    endtask

    // Check grants for the inputs currently applied, queue next-cycle write, advance one clock
    task automatic step(input logic g0, input logic g1, input logic we,
                        input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        #1;
        check("wb0_gnt", WB0_GNT, g0);
        check("wb1_gnt", WB1_GNT, g1);
        e.we = we; e.addr = a; e.data = d;
        sb.push_back(e);
        tick();
    endtask

    task automatic status(input logic ack, input logic busy);
        check("int_ack", INT_ACK, ack);
        check("busy", BUSY, busy);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET = 1'b1;
        WB0_REQ = 1'b1; WB0_ADDR = 5'd5; WB0_DATA = 32'h1;
        WB1_REQ = 1'b0; WB1_ADDR = '0;   WB1_DATA = '0;
        INT_REQ = 1'b0; INT_PC = '0;     RAND_IN = '0;

        // Two reset cycles with WB0 requesting: nothing granted or written
        step(0, 0, 0, 0, 0); status(0, 0);
        step(0, 0, 0, 0, 0); status(0, 0);

        // Single WB0 write
        RESET = 1'b0; WB0_ADDR = 5'd5; WB0_DATA = 32'hDEADBEEF;
        step(1, 0, 1, 5'd5, 32'hDEADBEEF); status(0, 0);
        WB0_REQ = 1'b0;
        step(0, 0, 0, 0, 0);

        // Re-reset so the pointer favours WB0, then continuous contention
        RESET = 1'b1;
        step(0, 0, 0, 0, 0);
        RESET = 1'b0;
        WB0_REQ = 1'b1; WB0_ADDR = 5'd1; WB0_DATA = 32'hA0;
        WB1_REQ = 1'b1; WB1_ADDR = 5'd2; WB1_DATA = 32'hB0;
        step(1, 0, 1, 5'd1, 32'hA0);
        WB0_ADDR = 5'd3; WB0_DATA = 32'hA1;
        step(0, 1, 1, 5'd2, 32'hB0);
        WB1_ADDR = 5'd4; WB1_DATA = 32'hB1;
        step(1, 0, 1, 5'd3, 32'hA1);
        WB0_REQ = 1'b0;
        step(0, 1, 1, 5'd4, 32'hB1);
        WB1_REQ = 1'b0;

        // Lone WB0 grant hands priority to WB1 on the next contention
        WB0_REQ = 1'b1; WB0_ADDR = 5'd6; WB0_DATA = 32'hC1;
        step(1, 0, 1, 5'd6, 32'hC1);
        WB0_ADDR = 5'd7; WB0_DATA = 32'hC2;
        WB1_REQ = 1'b1; WB1_ADDR = 5'd8; WB1_DATA = 32'hC3;
        step(0, 1, 1, 5'd8, 32'hC3);
        WB1_REQ = 1'b0;
        step(1, 0, 1, 5'd7, 32'hC2);
        WB0_REQ = 1'b0;

        // Interrupt with WB1 pending; INT_REQ held for 5 cycles
        INT_REQ = 1'b1; INT_PC = 32'h100; RAND_IN = 32'h55;
        WB1_REQ = 1'b1; WB1_ADDR = 5'd9; WB1_DATA = 32'h99;
        step(0, 0, 1, 5'd30, 32'h100); status(0, 1);
        RAND_IN = 32'h66; INT_PC = 32'h101;
        step(0, 0, 1, 5'd31, 32'h55); status(1, 1);
        step(0, 1, 1, 5'd9, 32'h99); status(1, 1);
        WB1_REQ = 1'b0;
        step(0, 0, 0, 0, 0); status(1, 1);
        step(0, 0, 0, 0, 0); status(1, 1);
        INT_REQ = 1'b0;
        step(0, 0, 0, 0, 0); status(0, 0);

        // Reassert after one low cycle: second save, then WB0 overwrites register 30
        INT_REQ = 1'b1; INT_PC = 32'h200; RAND_IN = 32'h77;
        step(0, 0, 1, 5'd30, 32'h200); status(0, 1);
        step(0, 0, 1, 5'd31, 32'h77); status(1, 1);
        INT_REQ = 1'b0;
        WB0_REQ = 1'b1; WB0_ADDR = 5'd30; WB0_DATA = 32'hAAAA;
        step(1, 0, 1, 5'd30, 32'hAAAA); status(0, 0);
        WB0_REQ = 1'b0;

        // Reset in the middle of a save abandons the RAND write
        INT_REQ = 1'b1; INT_PC = 32'h300; RAND_IN = 32'h88;
        step(0, 0, 1, 5'd30, 32'h300); status(0, 1);
        RESET = 1'b1;
        step(0, 0, 0, 0, 0); status(0, 0);
        RESET = 1'b0; INT_REQ = 1'b0;
        step(0, 0, 0, 0, 0); status(0, 0);

        // Write to register 0
        WB0_REQ = 1'b1; WB0_ADDR = 5'd0; WB0_DATA = 32'h1234;
`ifdef REG_WRITE_X0_DROP_EN
        step(1, 0, 0, 5'd0, 32'h1234);
`else
        step(1, 0, 1, 5'd0, 32'h1234);
`endif
        WB0_REQ = 1'b0;
        step(0, 0, 0, 0, 0); status(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_write_ctrl.md
Name: reg_write_ctrl

Overview:
- Write-port controller for the 32x32 CPU register file; owns the file's single write port (IN, INADDRESS, WRITE_EN).
- Shares the port between two writeback requesters, WB0 (ALU) and WB1 (load/NoC receive), using round-robin arbitration.
- Sequences the interrupt context save: PC to register INT_PC_REG, then the random/spike input to register INT_RAND_REG.
- Sits between the pipeline writeback stages and the register file; all register-file-side outputs are registered.

Parameters:
- INT_PC_REG, 30, register index that receives INT_PC on interrupt.
- INT_RAND_REG, 31, register index that receives RAND_IN on interrupt.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- WB0_REQ  input  1  writeback request, source 0.
- WB0_ADDR  input  5  destination register, source 0.
- WB0_DATA  input  32  write data, source 0.
- WB0_GNT  output  1  combinational grant, source 0; request consumed this cycle.
- WB1_REQ  input  1  writeback request, source 1.
- WB1_ADDR  input  5  destination register, source 1.
- WB1_DATA  input  32  write data, source 1.
- WB1_GNT  output  1  combinational grant, source 1.
- INT_REQ  input  1  level interrupt request.
- INT_PC  input  32  PC to save.
- RAND_IN  input  32  random/spike input to save.
- INT_ACK  output  1  registered; context save complete.
- BUSY  output  1  high while state is not IDLE.
- RF_IN  output  32  register file data input.
- RF_INADDRESS  output  5  register file write address.
- RF_WRITE_EN  output  1  register file write enable.

Behaviour:
- Reset: synchronous, active-high. State goes to IDLE; RF_IN=0, RF_INADDRESS=0, RF_WRITE_EN=0, INT_ACK=0, RAND hold register=0, round-robin pointer=0 (WB0 preferred). Both GNTs are 0 in any cycle with RESET=1. Reset mid-save abandons the save; no further writes.
- Latency: a request granted in cycle t appears on RF_* during cycle t+1. The register file writes it at the end of t+1.
- Handshake: a requester holds REQ/ADDR/DATA stable until it sees GNT=1 in the same cycle. At most one GNT per cycle. RF_WRITE_EN=0 in any cycle following a cycle with no write.
- Arbitration: active in IDLE and WAIT_REL only.
  - Only one source requests: that source is granted.
  - Both request: the source indicated by the pointer is granted, and the pointer flips to the other source.
  - A single-source grant sets the pointer to the other source.
- FSM states: IDLE, SAVE_RAND, WAIT_REL.
  - IDLE, INT_REQ=1: interrupt has priority; no GNT this cycle. Next RF_* = {INT_PC_REG, INT_PC, WE=1}. RAND_IN is captured into the hold register. Go to SAVE_RAND.
  - IDLE, INT_REQ=0: arbitrate normally.
  - SAVE_RAND: no GNT. Next RF_* = {INT_RAND_REG, hold, WE=1}. INT_ACK<=1. Go to WAIT_REL. This state lasts exactly one cycle.
  - WAIT_REL: arbitrate normally; INT_ACK stays 1. When INT_REQ=0, INT_ACK<=0 and go to IDLE. An interrupt therefore cannot retrigger until INT_REQ has been low for at least one cycle.
- BUSY = (state != IDLE).
- Boundaries:
  - A WB request pending during a save is held off; grant resumes in WAIT_REL.
  - A WB write to INT_PC_REG/INT_RAND_REG in a later cycle overwrites the saved value; ordering is strictly by grant cycle.
  - ADDR/DATA are passed through unmodified, except as stated under the optional feature.

Optional Feature:
- Macro: REG_WRITE_X0_DROP_EN.
- Defined: a granted WB request with ADDR=0 is still granted (GNT=1, pointer updated) but produces RF_WRITE_EN=0 in the next cycle. Register 0 reads as written at reset (0).
- Undefined: address 0 is written like any other register.
- Interrupt writes are unaffected in both cases.

Test Plan:
- RESET=1 for 2 cycles with WB0_REQ=1 -> WB0_GNT=0, RF_WRITE_EN=0, INT_ACK=0, BUSY=0.
- WB0_REQ=1, ADDR=5, DATA=0xDEADBEEF for one cycle after reset -> WB0_GNT=1 that cycle; next cycle RF_INADDRESS=5, RF_IN=0xDEADBEEF, RF_WRITE_EN=1.
- WB0 and WB1 both requesting continuously for 4 cycles after reset -> grants WB0, WB1, WB0, WB1; RF_* follow one cycle later.
- IDLE, INT_REQ=1, INT_PC=0x100, RAND_IN=0x55, WB1_REQ=1 -> no GNT for 2 cycles; RF writes {30,0x100} then {31,0x55}; INT_ACK=1 while INT_REQ held; WB1 granted in the first WAIT_REL cycle.
- INT_REQ held 5 cycles -> exactly one save sequence. Drop INT_REQ for 1 cycle and reassert -> second save sequence.
- Macro defined, WB0_REQ with ADDR=0 -> WB0_GNT=1, following cycle RF_WRITE_EN=0. Macro undefined -> RF_WRITE_EN=1, RF_INADDRESS=0.
